// File: rtl/alu_uart_interface.sv
// alu_uart_interface
// Sequencing front-end between a UART RX/TX pair and a combinational ALU.
// Three consecutive received bytes (operand A, operand B, opcode) are driven
// onto the ALU inputs. The ALU result is latched one cycle later and handed
// to the transmitter with a single-cycle tx_start pulse.
//
// Optional feature: define ALU_IF_TIMEOUT_EN to abandon a partially received
// operation after TIMEOUT_CYCLES idle cycles in WAIT_B/WAIT_OP and raise a
// sticky error flag. Without the macro the block waits indefinitely and
// error is tied low.
module alu_uart_interface #(
  parameter int NBITS          = 8,
  parameter int COD_OP         = 6,
  parameter int TIMEOUT_CYCLES = 1000000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              rx_done,
  input  logic [NBITS-1:0]  rx_data,
  input  logic              tx_done,
  output logic              tx_start,
  output logic [NBITS-1:0]  tx_data,
  output logic [NBITS-1:0]  operando_A,
  output logic [NBITS-1:0]  operando_B,
  output logic [COD_OP-1:0] cod_operacion,
  input  logic [NBITS-1:0]  ALU_Result,
  output logic              busy,
  output logic              error
);

  typedef enum logic [2:0] {
    WAIT_A,
    WAIT_B,
    WAIT_OP,
    EXEC,
    SEND,
    WAIT_TX
  } state_t;

  state_t state;

`ifdef ALU_IF_TIMEOUT_EN
  // Counter is wide enough to reach TIMEOUT_CYCLES-1; never narrower than 1 bit.
  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;

  logic [CW-1:0] idle_cnt;
  logic          expired;

  assign expired = (idle_cnt == CW'(TIMEOUT_CYCLES - 1));
`else
  // No timeout hardware: the flag is constant and the length is unused.
  logic unused_timeout;

  assign unused_timeout = ^TIMEOUT_CYCLES;
  assign error          = 1'b0;
`endif

  // Sequencer: state, operand/opcode registers, result latch and the
  // registered tx_start/busy/error outputs all update together.
  // NOTE: every register here uses non-blocking assignment so all of them
  // see the pre-edge values of state and of each other.
  always_ff @(posedge clk) begin
    if (reset) begin
      state         <= WAIT_A;
      operando_A    <= '0;
      operando_B    <= '0;
      cod_operacion <= '0;
      tx_data       <= '0;
      tx_start      <= 1'b0;
      busy          <= 1'b0;
`ifdef ALU_IF_TIMEOUT_EN
      error         <= 1'b0;
      idle_cnt      <= '0;
`endif
    end else begin
      // tx_start is a one-cycle pulse; only EXEC raises it.
      tx_start <= 1'b0;

      case (state)
        WAIT_A: begin
          if (rx_done) begin
            operando_A <= rx_data;
            state      <= WAIT_B;
`ifdef ALU_IF_TIMEOUT_EN
            error      <= 1'b0;
            idle_cnt   <= '0;
`endif
          end
        end

        WAIT_B: begin
          if (rx_done) begin
            operando_B <= rx_data;
            state      <= WAIT_OP;
`ifdef ALU_IF_TIMEOUT_EN
            idle_cnt   <= '0;
          end else if (expired) begin
            state      <= WAIT_A;
            error      <= 1'b1;
          end else begin
            idle_cnt   <= idle_cnt + 1'b1;
`endif
          end
        end

        WAIT_OP: begin
          if (rx_done) begin
            // Upper byte bits beyond the opcode width are discarded.
            cod_operacion <= rx_data[COD_OP-1:0];
            state         <= EXEC;
            busy          <= 1'b1;
`ifdef ALU_IF_TIMEOUT_EN
            idle_cnt      <= '0;
          end else if (expired) begin
            state         <= WAIT_A;
            error         <= 1'b1;
          end else begin
            idle_cnt      <= idle_cnt + 1'b1;
`endif
          end
        end

        // One settle cycle for the combinational ALU, then latch its result.
        EXEC: begin
          tx_data  <= ALU_Result;
          tx_start <= 1'b1;
          state    <= SEND;
        end

        SEND: begin
          state <= WAIT_TX;
        end

        WAIT_TX: begin
          if (tx_done) begin
            busy  <= 1'b0;
            state <= WAIT_A;
          end
        end

        default: begin
          state <= WAIT_A;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule
